// File: rtl/entradas_pkg.sv
// -----------------------------------------------------------------------------
// entradas_pkg
// Shared definitions for the MicroUAZ input-port read unit.
//   SEL_DIRECTO   : SELEC code, port address taken from the RY index
//   SEL_INDIRECTO : SELEC code, port address taken from the contents of RY
//   estado_t      : handshake FSM states
//   es_selec_valido() : true for the SELEC codes this unit responds to
// The SEL_* codes are also decoded by the output unit, so keep them in sync.
// -----------------------------------------------------------------------------
package entradas_pkg;

    localparam logic [2:0] SEL_DIRECTO   = 3'b001;
    localparam logic [2:0] SEL_INDIRECTO = 3'b010;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        PETICION  = 2'd1,
        ESCRITURA = 2'd2,
        LIBERA    = 2'd3
    } estado_t;

    function automatic logic es_selec_valido(input logic [2:0] selec);
        return (selec == SEL_DIRECTO) || (selec == SEL_INDIRECTO);
    endfunction

endpackage

// File: rtl/entradas_if.sv
// -----------------------------------------------------------------------------
// entradas_if
// Bundles the decoder request, the external input bus handshake and the
// register-file write port of the input unit.
//   master : decoder / device / register-file side
//   slave  : the entradas unit
//   INICIO, SELEC, RX, RY, RY_DATO : request from the instruction decoder
//   DATO_IN, LISTO_IN              : data and acknowledge from the device
//   DIR_IN, LEER                   : port address and read request to device
//   ESCRIBE_RX, RX_DIR, RX_DATO    : register-file write strobe/index/data
//   OCUPADO, ERROR_TO              : busy and sticky timeout status
// -----------------------------------------------------------------------------
interface entradas_if;

    logic       INICIO;
    logic [2:0] SELEC;
    logic [2:0] RX;
    logic [2:0] RY;
    logic [7:0] RY_DATO;
    logic [7:0] DATO_IN;
    logic       LISTO_IN;
    logic [7:0] DIR_IN;
    logic       LEER;
    logic       ESCRIBE_RX;
    logic [2:0] RX_DIR;
    logic [7:0] RX_DATO;
    logic       OCUPADO;
    logic       ERROR_TO;

    modport master (
        output INICIO, SELEC, RX, RY, RY_DATO, DATO_IN, LISTO_IN,
        input  DIR_IN, LEER, ESCRIBE_RX, RX_DIR, RX_DATO, OCUPADO, ERROR_TO
    );

    modport slave (
        input  INICIO, SELEC, RX, RY, RY_DATO, DATO_IN, LISTO_IN,
        output DIR_IN, LEER, ESCRIBE_RX, RX_DIR, RX_DATO, OCUPADO, ERROR_TO
    );

endinterface

// File: rtl/entradas_contador_to.sv
// -----------------------------------------------------------------------------
// contador_to
// Saturating wait counter shared by both handshake wait states.
//   clk   : clock, rising edge
//   srst  : synchronous active-high reset
//   i_clr : clear the count (has priority over i_en)
//   i_en  : advance the count by one
//   o_fin : count has reached TIMEOUT-1, the wait has expired
// The count stops at TIMEOUT-1 instead of wrapping, so o_fin stays asserted
// until cleared.
// -----------------------------------------------------------------------------
module contador_to #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic srst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_fin
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_fin = (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (srst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_fin) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/entradas.sv
// -----------------------------------------------------------------------------
// entradas
// Input-port read unit. On an accepted INICIO it latches the port address and
// destination register, raises LEER until the device acknowledges with
// LISTO_IN, captures DATO_IN, pulses ESCRIBE_RX for one cycle and then waits
// for LISTO_IN to drop. Either wait aborts after TIMEOUT cycles and sets the
// sticky ERROR_TO flag.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : entradas_if.slave (decoder request, device handshake, RF write)
// -----------------------------------------------------------------------------
module entradas
    import entradas_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    entradas_if.slave   bus
);

    estado_t    r_state;
    estado_t    w_next_state;
    logic [7:0] r_dir_in;
    logic [2:0] r_rx_dir;
    logic [7:0] r_rx_dato;
    logic       r_error_to;

    logic       w_acepta;
    logic       w_captura;
    logic       w_timeout;
    logic       w_cnt_clr;
    logic       w_cnt_en;
    logic       w_cnt_fin;
    logic [7:0] w_dir;

    // Address is resolved from the decoder fields at the moment of acceptance.
    assign w_dir = (bus.SELEC == SEL_DIRECTO) ? {5'b00000, bus.RY} : bus.RY_DATO;

    contador_to #(
        .TIMEOUT (TIMEOUT)
    ) u_contador_to (
        .clk   (CLK),
        .srst  (RST),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_fin (w_cnt_fin)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= REPOSO;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_acepta     = 1'b0;
        w_captura    = 1'b0;
        w_timeout    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            REPOSO: begin
                // Holding the counter clear while idle means each wait starts at 0.
                w_cnt_clr = 1'b1;
                if (bus.INICIO && es_selec_valido(bus.SELEC)) begin
                    w_acepta     = 1'b1;
                    w_next_state = PETICION;
                end
            end
            PETICION: begin
                if (bus.LISTO_IN) begin
                    w_captura    = 1'b1;
                    w_next_state = ESCRITURA;
                end else if (w_cnt_fin) begin
                    w_timeout    = 1'b1;
                    w_next_state = REPOSO;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ESCRITURA: begin
                w_cnt_clr    = 1'b1;
                w_next_state = LIBERA;
            end
            LIBERA: begin
                if (!bus.LISTO_IN) begin
                    w_next_state = REPOSO;
                end else if (w_cnt_fin) begin
                    w_timeout    = 1'b1;
                    w_next_state = REPOSO;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            default: begin
                w_next_state = REPOSO;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dir_in   <= 8'h00;
            r_rx_dir   <= 3'b000;
            r_rx_dato  <= 8'h00;
            r_error_to <= 1'b0;
        end else begin
            if (w_acepta) begin
                r_dir_in   <= w_dir;
                r_rx_dir   <= bus.RX;
                r_error_to <= 1'b0;
            end
            if (w_captura) begin
                r_rx_dato <= bus.DATO_IN;
            end
            if (w_timeout) begin
                r_error_to <= 1'b1;
            end
        end
    end

    assign bus.DIR_IN     = r_dir_in;
    assign bus.RX_DIR     = r_rx_dir;
    assign bus.RX_DATO    = r_rx_dato;
    assign bus.ERROR_TO   = r_error_to;
    assign bus.LEER       = (r_state == PETICION);
    assign bus.ESCRIBE_RX = (r_state == ESCRITURA);
    assign bus.OCUPADO    = (r_state != REPOSO);

endmodule
